spi_m_sched: RTL and testbench
==============================

SPI_M_SCHED -- requirements
Module: spi_m_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one SPI byte engine; legal range 2..8.
REQ-002 Parameter CS_SETUP, default 2: clock cycles cs_n is held low before the first byte starts.
REQ-003 Parameter CS_HOLD, default 2: clock cycles cs_n is held low after the last byte completes.
REQ-004 clock  in  1  single clock; all logic is on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 req  in  NREQ  per-requester transaction request, level.
REQ-007 len  in  NREQ*8  per-requester byte count; slice i is [8i+7:8i].
REQ-008 tx_data  in  NREQ*8  per-requester transmit byte.
REQ-009 tx_valid  in  NREQ  transmit byte valid.
REQ-010 tx_ready  out  NREQ  transmit byte accepted when tx_valid[i] and tx_ready[i] are both high.
REQ-011 rx_data  out  8  received byte, shared by all requesters.
REQ-012 rx_valid  out  NREQ  one-cycle pulse; rx_data is valid for requester i.
REQ-013 grant  out  NREQ  one-hot; identifies the current owner.
REQ-014 done  out  NREQ  one-cycle pulse at the end of a transaction.
REQ-015 cs_n  out  NREQ  per-requester chip select, active-low.
REQ-016 eng_start  out  1  one-cycle pulse that starts one byte exchange in the engine.
REQ-017 eng_txd  out  8  byte to the engine; held stable from eng_start until eng_done.
REQ-018 eng_busy  in  1  engine busy.
REQ-019 eng_done  in  1  one-cycle pulse; eng_rxd is valid.
REQ-020 eng_rxd  in  8  byte received by the engine.

Function
REQ-021 The FSM shall have the states IDLE, SETUP, LOAD, XFER, HOLD and FIN.
REQ-022 In IDLE, when any req bit is high, the block shall choose the owner round-robin, searching from (last+1) mod NREQ, and shall latch the owner index and len[owner] into remaining.
- After reset, last = NREQ-1, so requester 0 has first priority.
REQ-023 With a latched len of 0, the next state shall be FIN and cs_n shall not be asserted.
- Otherwise the next state shall be SETUP.
REQ-024 On entry to SETUP, grant[owner] and cs_n[owner]=0 shall assert.
- SETUP shall last exactly CS_SETUP cycles, then move to LOAD.
- CS_SETUP=0 shall go directly to LOAD.
REQ-025 In LOAD, tx_ready[owner]=1 only while eng_busy=0.
- On acceptance of a byte, eng_txd shall latch tx_data[owner].
- eng_start shall pulse on the following cycle and the state shall move to XFER.
REQ-026 In XFER, on eng_done the block shall register rx_data<=eng_rxd, pulse rx_valid[owner] one cycle later, and decrement remaining.
- If remaining reaches 0, the next state shall be HOLD; otherwise LOAD.
REQ-027 HOLD shall keep cs_n[owner] low for CS_HOLD cycles, then move to FIN.
REQ-028 FIN shall last exactly one cycle with cs_n all high, done[owner]=1 and grant=0.
- In FIN, last shall be set to owner, and the next state shall be IDLE.
REQ-029 A transaction is never pre-empted.
- req changes by other requesters shall not affect the owner.
REQ-030 If req[owner] falls in LOAD, the block shall go to HOLD without another byte.
- If req[owner] falls in XFER, the block shall complete the current byte, then go to HOLD.
- In both cases done shall still pulse.
REQ-031 The block shall not issue eng_start while eng_busy=1.
- An eng_done outside XFER shall be ignored.
REQ-032 At most one bit of each of grant, cs_n-low, tx_ready, rx_valid and done shall be active at any time.
REQ-033 Minimum transaction length = CS_SETUP + len*(2 + engine latency) + CS_HOLD + 2 cycles.

Reset
REQ-034 Asserting reset_n=0 shall immediately force, without waiting for a clock edge:
- state=IDLE, cs_n all 1, grant, tx_ready, rx_valid, done and eng_start all 0;
- eng_txd, rx_data and remaining = 0; last = NREQ-1.
REQ-035 Reset asserted mid-transaction shall abandon the transaction with no done pulse.
REQ-036 Operation shall resume on the first rising clock edge after reset_n is released.

Verification
REQ-037 Single transfer: req[1]=1, len=3, tx 0xA5,0x5A,0xFF, engine echoes inverted bytes -> cs_n[1] low 2 cycles before the first eng_start; rx_valid[1] x3 with 0x5A,0xA5,0x00; done[1] once; cs_n[1] high afterward.
REQ-038 Round-robin: req=4'b1111 held, len=1 each -> grant order 0,1,2,3,0; no cs_n overlap.
REQ-039 len=0 on requester 2 -> done[2] pulses within 3 cycles; cs_n[2] never low; eng_start never pulses.
REQ-040 Abort: len=5, drop req[0] after the 2nd eng_start -> exactly 2 bytes exchanged, HOLD, then done[0].
REQ-041 Backpressure: eng_busy=1 for 10 cycles in LOAD -> tx_ready low and no eng_start until eng_busy=0.
REQ-042 Reset mid-XFER -> all outputs at reset values while reset_n=0, no done pulse; a new req[3] is then served normally.

Source files
------------

// File: rtl/spi_m_sched.sv
// spi_m_sched: schedules transactions from NREQ requesters onto one shared
// SPI byte engine. Requesters are served round-robin and an owner keeps the
// engine until its transaction ends. Each transaction is framed by the
// owner's chip select: CS_SETUP cycles of setup, one engine exchange per
// byte, then CS_HOLD cycles of hold, and a one-cycle FIN that pulses done.
//
// Ports
//   clock_i      single clock, rising edge
//   reset_n_i    asynchronous active-low reset
//   req_i        per-requester transaction request (level)
//   len_i        per-requester byte count, slice i is [8i+7:8i]
//   tx_data_i    per-requester transmit byte, same slicing as len_i
//   tx_valid_i   per-requester transmit byte valid
//   tx_ready_o   per-requester transmit byte accept
//   rx_data_o    received byte, shared by all requesters
//   rx_valid_o   one-cycle pulse, rx_data_o belongs to requester i
//   grant_o      one-hot current owner
//   done_o       one-cycle pulse at the end of a transaction
//   cs_n_o       per-requester chip select, active-low
//   eng_start_o  one-cycle pulse starting one engine byte exchange
//   eng_txd_o    byte to the engine, stable from eng_start_o to eng_done_i
//   eng_busy_i   engine busy
//   eng_done_i   one-cycle pulse, eng_rxd_i valid
//   eng_rxd_i    byte received by the engine
module spi_m_sched #(
    parameter int NREQ     = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*8-1:0] len_i,
    input  logic [NREQ*8-1:0] tx_data_i,
    input  logic [NREQ-1:0]   tx_valid_i,
    output logic [NREQ-1:0]   tx_ready_o,
    output logic [7:0]        rx_data_o,
    output logic [NREQ-1:0]   rx_valid_o,
    output logic [NREQ-1:0]   grant_o,
    output logic [NREQ-1:0]   done_o,
    output logic [NREQ-1:0]   cs_n_o,
    output logic              eng_start_o,
    output logic [7:0]        eng_txd_o,
    input  logic              eng_busy_i,
    input  logic              eng_done_i,
    input  logic [7:0]        eng_rxd_i
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        XFER,
        HOLD,
        FIN
    } state_t;

    // Zero-length setup or hold phases are skipped entirely.
    localparam state_t SETUP_NEXT = (CS_SETUP == 0) ? LOAD : SETUP;
    localparam state_t HOLD_NEXT  = (CS_HOLD == 0) ? FIN : HOLD;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [7:0]      remaining_q, remaining_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      eng_txd_q, eng_txd_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            eng_start_q, eng_start_d;
    logic [NREQ-1:0] rx_valid_q, rx_valid_d;

    logic [IW-1:0]   pick;
    logic            found;
    logic [7:0]      pick_len;
    logic [NREQ-1:0] owner_oh;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        pick  = last_q;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req_i[(int'(last_q) + i) % NREQ]) begin
                found = 1'b1;
                pick  = IW'((int'(last_q) + i) % NREQ);
            end
        end
    end

    assign pick_len = len_i[int'(pick)*8 +: 8];
    assign owner_oh = NREQ'(1) << owner_q;

    // Next-state and output decode. grant/cs_n/tx_ready/done are pure
    // functions of the registered state, so reset clears them at once.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;
        eng_txd_d   = eng_txd_q;
        rx_data_d   = rx_data_q;
        eng_start_d = 1'b0;
        rx_valid_d  = '0;
        grant_o     = '0;
        cs_n_o      = '1;
        tx_ready_o  = '0;
        done_o      = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d     = pick;
                    remaining_d = pick_len;
                    cnt_d       = 8'd0;
                    state_d     = (pick_len == 8'd0) ? FIN : SETUP_NEXT;
                end
            end
            SETUP: begin
                grant_o = owner_oh;
                cs_n_o  = ~owner_oh;
                if (cnt_q == 8'(CS_SETUP - 1)) begin
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            LOAD: begin
                grant_o = owner_oh;
                cs_n_o  = ~owner_oh;
                // A withdrawn request ends the transaction before another byte.
                if (!req_i[owner_q]) begin
                    cnt_d   = 8'd0;
                    state_d = HOLD_NEXT;
                end else if (!eng_busy_i) begin
                    tx_ready_o = owner_oh;
                    if (tx_valid_i[owner_q]) begin
                        eng_txd_d   = tx_data_i[int'(owner_q)*8 +: 8];
                        eng_start_d = 1'b1;
                        state_d     = XFER;
                    end
                end
            end
            XFER: begin
                grant_o = owner_oh;
                cs_n_o  = ~owner_oh;
                // A done coincident with our own start pulse cannot belong to
                // this byte, so it is not taken as completion.
                if (eng_done_i && !eng_start_q) begin
                    rx_data_d   = eng_rxd_i;
                    rx_valid_d  = owner_oh;
                    remaining_d = remaining_q - 8'd1;
                    cnt_d       = 8'd0;
                    if (remaining_q == 8'd1 || !req_i[owner_q]) begin
                        state_d = HOLD_NEXT;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            HOLD: begin
                grant_o = owner_oh;
                cs_n_o  = ~owner_oh;
                if (cnt_q == 8'(CS_HOLD - 1)) begin
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FIN: begin
                done_o  = owner_oh;
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            last_q      <= IW'(NREQ - 1);
            remaining_q <= 8'd0;
            cnt_q       <= 8'd0;
            eng_txd_q   <= 8'd0;
            rx_data_q   <= 8'd0;
            eng_start_q <= 1'b0;
            rx_valid_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            eng_txd_q   <= eng_txd_d;
            rx_data_q   <= rx_data_d;
            eng_start_q <= eng_start_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    assign eng_start_o = eng_start_q;
    assign eng_txd_o   = eng_txd_q;
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;

endmodule

// File: tb/tb_spi_m_sched.sv
// tb_spi_m_sched: self-checking bench for spi_m_sched. A behavioural SPI
// engine echoes the inverted transmit byte after a random latency, per-
// requester byte sources feed tx_data, and a monitor logs rx, grant and
// done events. Expected orderings and bytes come from a round-robin model.
module tb_spi_m_sched;

    localparam int NREQ     = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;

    logic              clock    = 1'b0;
    logic              reset_n  = 1'b1;
    logic [NREQ-1:0]   req      = '0;
    logic [NREQ*8-1:0] len      = '0;
    logic [NREQ*8-1:0] tx_data  = '0;
    logic [NREQ-1:0]   tx_valid = '0;
    logic [NREQ-1:0]   tx_ready;
    logic [7:0]        rx_data;
    logic [NREQ-1:0]   rx_valid;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   cs_n;
    logic              eng_start;
    logic [7:0]        eng_txd;
    logic              eng_busy_m = 1'b0;
    logic              bp_busy    = 1'b0;
    logic              eng_busy;
    logic              eng_done   = 1'b0;
    logic [7:0]        eng_rxd    = 8'h00;

    assign eng_busy = eng_busy_m | bp_busy;

    int checks   = 0;
    int failures = 0;

    // Byte sources and monitor state
    logic [7:0]      txmem [NREQ][16];
    int              txcnt [NREQ];
    int              txrd  [NREQ];
    logic [NREQ-1:0] hs = '0;
    logic [NREQ-1:0] prev_grant = '0;
    logic [NREQ-1:0] cs_seen = '0;
    int              mon_rx_own[$];
    logic [7:0]      mon_rx_dat[$];
    int              mon_grant[$];
    int              mon_done[$];
    int              start_cnt = 0;
    int              lead = 0;
    int              last_lead = 0;
    bit              started = 1'b0;
    bit              pend = 1'b0;
    logic [7:0]      cap = 8'h00;

    spi_m_sched #(.NREQ(NREQ), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
        .clock_i    (clock),
        .reset_n_i  (reset_n),
        .req_i      (req),
        .len_i      (len),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .grant_o    (grant),
        .done_o     (done),
        .cs_n_o     (cs_n),
        .eng_start_o(eng_start),
        .eng_txd_o  (eng_txd),
        .eng_busy_i (eng_busy),
        .eng_done_i (eng_done),
        .eng_rxd_i  (eng_rxd)
    );

    always #5 clock = ~clock;

    function automatic int idx_of(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Round-robin reference: first pending requester after 'last'.
    function automatic int rr_pick(input int last, input logic [NREQ-1:0] mask);
        for (int j = 1; j <= NREQ; j++) if (mask[(last + j) % NREQ]) return (last + j) % NREQ;
        return -1;
    endfunction

    // Behavioural engine: goes busy the cycle after eng_start, stays busy a
    // random 1..3 cycles, then pulses eng_done with the inverted byte.
    initial begin
        int ecnt;
        ecnt = 0;
        forever begin
            @(posedge clock);
            #1;
            eng_done = 1'b0;
            if (!reset_n) begin
                eng_busy_m = 1'b0;
                pend = 1'b0;
                ecnt = 0;
            end else if (pend) begin
                pend = 1'b0;
                eng_busy_m = 1'b1;
                ecnt = $urandom_range(1, 3);
            end else if (eng_busy_m) begin
                ecnt--;
                if (ecnt == 0) begin
                    eng_busy_m = 1'b0;
                    eng_done = 1'b1;
                    eng_rxd = ~cap;
                end
            end
        end
    end

    // Transmit byte sources: pop on a handshake seen in the previous cycle.
    initial begin
        for (int i = 0; i < NREQ; i++) begin
            txcnt[i] = 0;
            txrd[i] = 0;
        end
        forever begin
            @(posedge clock);
            #2;
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i]) txrd[i]++;
                tx_valid[i] = (txrd[i] < txcnt[i]);
                tx_data[i*8 +: 8] = tx_valid[i] ? txmem[i][txrd[i]] : 8'h00;
            end
        end
    end

    // Monitor: event logs plus always-on protocol invariants.
    initial begin
        forever begin
            @(negedge clock);
            hs = tx_valid & tx_ready;
            checks++;
            if ($countones(grant) > 1 || $countones(~cs_n) > 1 || $countones(tx_ready) > 1 ||
                $countones(rx_valid) > 1 || $countones(done) > 1) begin
                failures++;
                $display("[TB] FAIL onehot: grant=%b cs_n=%b tx_ready=%b rx_valid=%b done=%b, required at most one active each",
                         grant, cs_n, tx_ready, rx_valid, done);
            end
            checks++;
            if ((~cs_n & ~grant) != '0) begin
                failures++;
                $display("[TB] FAIL cs_vs_grant: cs_n=%b grant=%b, required cs low only on the granted requester", cs_n, grant);
            end
            checks++;
            if (eng_start && eng_busy) begin
                failures++;
                $display("[TB] FAIL start_while_busy: eng_start=1 eng_busy=1, required no start while busy");
            end
            if (pend || eng_busy_m) begin
                checks++;
                if (eng_txd !== cap) begin
                    failures++;
                    $display("[TB] FAIL txd_stable: eng_txd=%h, required %h", eng_txd, cap);
                end
            end
            if (eng_start) begin
                start_cnt++;
                pend = 1'b1;
                cap = eng_txd;
            end
            if (rx_valid != '0) begin
                mon_rx_own.push_back(idx_of(rx_valid));
                mon_rx_dat.push_back(rx_data);
            end
            if (done != '0) mon_done.push_back(idx_of(done));
            if (grant != '0 && prev_grant == '0) begin
                mon_grant.push_back(idx_of(grant));
                lead = 0;
                started = 1'b0;
            end
            if (cs_n != '1 && !started) begin
                if (eng_start) begin
                    started = 1'b1;
                    last_lead = lead;
                end else begin
                    lead++;
                end
            end
            cs_seen = cs_seen | ~cs_n;
            prev_grant = grant;
        end
    end

    task automatic clear_logs();
        mon_rx_own.delete();
        mon_rx_dat.delete();
        mon_grant.delete();
        mon_done.delete();
        start_cnt = 0;
        cs_seen = '0;
    endtask

    task automatic load_txn(input int r, input int n);
        txcnt[r] = n;
        txrd[r] = 0;
        for (int k = 0; k < n; k++) txmem[r][k] = 8'($urandom);
        len[r*8 +: 8] = 8'(n);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset_n = 1'b0;
        req = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // Drop each requester's req after its done; bounded by maxc cycles.
    task automatic wait_idle(input int maxc);
        int n;
        logic [NREQ-1:0] d;
        n = 0;
        while (req != '0 && n < maxc) begin
            @(negedge clock);
            n++;
            if (done != '0) begin
                d = done;
                @(posedge clock);
                #1;
                req = req & ~d;
            end
        end
        checks++;
        if (req != '0) begin
            failures++;
            $display("[TB] FAIL wait_idle timeout: req=%b after %0d cycles, required 0", req, n);
            req = '0;
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic test_reset();
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (cs_n !== '1) begin failures++; $display("[TB] FAIL reset cs_n: got %b required %b", cs_n, {NREQ{1'b1}}); end
        checks++; if (grant !== '0) begin failures++; $display("[TB] FAIL reset grant: got %b required 0", grant); end
        checks++; if (tx_ready !== '0) begin failures++; $display("[TB] FAIL reset tx_ready: got %b required 0", tx_ready); end
        checks++; if (rx_valid !== '0) begin failures++; $display("[TB] FAIL reset rx_valid: got %b required 0", rx_valid); end
        checks++; if (done !== '0) begin failures++; $display("[TB] FAIL reset done: got %b required 0", done); end
        checks++; if (eng_start !== 1'b0) begin failures++; $display("[TB] FAIL reset eng_start: got %b required 0", eng_start); end
        checks++; if (eng_txd !== 8'h00) begin failures++; $display("[TB] FAIL reset eng_txd: got %h required 00", eng_txd); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset rx_data: got %h required 00", rx_data); end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single();
        logic [7:0] exp_rx [3];
        exp_rx[0] = 8'h5A;
        exp_rx[1] = 8'hA5;
        exp_rx[2] = 8'h00;
        clear_logs();
        @(posedge clock);
        #1;
        load_txn(1, 3);
        txmem[1][0] = 8'hA5;
        txmem[1][1] = 8'h5A;
        txmem[1][2] = 8'hFF;
        req = 4'b0010;
        wait_idle(400);
        checks++; if (mon_rx_own.size() != 3) begin failures++; $display("[TB] FAIL single rx count: got %0d required 3", mon_rx_own.size()); end
        for (int k = 0; k < 3 && k < mon_rx_own.size(); k++) begin
            checks++;
            if (mon_rx_own[k] != 1 || mon_rx_dat[k] !== exp_rx[k]) begin
                failures++;
                $display("[TB] FAIL single rx[%0d]: got req%0d %h required req1 %h", k, mon_rx_own[k], mon_rx_dat[k], exp_rx[k]);
            end
        end
        checks++; if (mon_done.size() != 1 || mon_done[0] != 1) begin failures++; $display("[TB] FAIL single done: got %0d pulses, required one on req1", mon_done.size()); end
        checks++; if (start_cnt != 3) begin failures++; $display("[TB] FAIL single starts: got %0d required 3", start_cnt); end
        checks++; if (cs_n[1] !== 1'b1) begin failures++; $display("[TB] FAIL single cs_n after: got %b required 1", cs_n[1]); end
        checks++;
        if (last_lead < CS_SETUP || last_lead > CS_SETUP + 1) begin
            failures++;
            $display("[TB] FAIL single cs lead: got %0d cycles required %0d..%0d", last_lead, CS_SETUP, CS_SETUP + 1);
        end
    endtask

    task automatic test_round_robin();
        int n;
        int ndone;
        int own;
        int last;
        int used [NREQ];
        logic [7:0] exp_b;
        pulse_reset();
        clear_logs();
        @(posedge clock);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            load_txn(i, 1);
            used[i] = 0;
        end
        txmem[0][1] = 8'($urandom);
        txcnt[0] = 2;
        req = 4'b1111;
        n = 0;
        ndone = 0;
        while (ndone < 5 && n < 1000) begin
            @(negedge clock);
            n++;
            if (done != '0) ndone++;
        end
        @(posedge clock);
        #1;
        req = '0;
        repeat (10) @(negedge clock);
        checks++; if (mon_grant.size() != 5) begin failures++; $display("[TB] FAIL rr grant count: got %0d required 5", mon_grant.size()); end
        last = NREQ - 1;
        for (int k = 0; k < 5 && k < mon_grant.size(); k++) begin
            own = rr_pick(last, 4'b1111);
            exp_b = ~txmem[own][used[own]];
            used[own]++;
            last = own;
            checks++;
            if (mon_grant[k] != own) begin
                failures++;
                $display("[TB] FAIL rr grant[%0d]: got %0d required %0d", k, mon_grant[k], own);
            end
            if (k < mon_rx_dat.size()) begin
                checks++;
                if (mon_rx_dat[k] !== exp_b || mon_rx_own[k] != own) begin
                    failures++;
                    $display("[TB] FAIL rr rx[%0d]: got req%0d %h required req%0d %h", k, mon_rx_own[k], mon_rx_dat[k], own, exp_b);
                end
            end
        end
    endtask

    task automatic test_len_zero();
        int t;
        clear_logs();
        @(posedge clock);
        #1;
        load_txn(2, 0);
        req = 4'b0100;
        t = 0;
        while (done == '0 && t < 10) begin
            @(negedge clock);
            t++;
        end
        checks++;
        if (done !== 4'b0100 || t > 3) begin
            failures++;
            $display("[TB] FAIL len0 done: got %b after %0d cycles, required 0100 within 3", done, t);
        end
        @(posedge clock);
        #1;
        req = '0;
        repeat (5) @(negedge clock);
        checks++; if (cs_seen != '0) begin failures++; $display("[TB] FAIL len0 cs: got cs-low mask %b required 0000", cs_seen); end
        checks++; if (start_cnt != 0) begin failures++; $display("[TB] FAIL len0 starts: got %0d required 0", start_cnt); end
        checks++; if (mon_done.size() != 1) begin failures++; $display("[TB] FAIL len0 done count: got %0d required 1", mon_done.size()); end
    endtask

    task automatic test_abort();
        int n;
        clear_logs();
        @(posedge clock);
        #1;
        load_txn(0, 5);
        req = 4'b0001;
        n = 0;
        while (start_cnt < 2 && n < 400) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        req = '0;
        n = 0;
        while (mon_done.size() == 0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        repeat (5) @(negedge clock);
        checks++; if (start_cnt != 2) begin failures++; $display("[TB] FAIL abort starts: got %0d required 2", start_cnt); end
        checks++; if (mon_rx_own.size() != 2) begin failures++; $display("[TB] FAIL abort rx count: got %0d required 2", mon_rx_own.size()); end
        for (int k = 0; k < 2 && k < mon_rx_dat.size(); k++) begin
            checks++;
            if (mon_rx_dat[k] !== ~txmem[0][k]) begin
                failures++;
                $display("[TB] FAIL abort rx[%0d]: got %h required %h", k, mon_rx_dat[k], ~txmem[0][k]);
            end
        end
        checks++; if (mon_done.size() != 1 || mon_done[0] != 0) begin failures++; $display("[TB] FAIL abort done: got %0d pulses, required one on req0", mon_done.size()); end
    endtask

    task automatic test_backpressure();
        clear_logs();
        @(posedge clock);
        #1;
        bp_busy = 1'b1;
        load_txn(3, 1);
        req = 4'b1000;
        repeat (12) begin
            @(negedge clock);
            checks++;
            if (tx_ready !== '0 || eng_start !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bp stall: tx_ready=%b eng_start=%b, required 0 and 0 while busy", tx_ready, eng_start);
            end
        end
        checks++; if (grant !== 4'b1000) begin failures++; $display("[TB] FAIL bp grant: got %b required 1000", grant); end
        @(posedge clock);
        #1;
        bp_busy = 1'b0;
        wait_idle(300);
        checks++; if (start_cnt != 1) begin failures++; $display("[TB] FAIL bp starts: got %0d required 1", start_cnt); end
        checks++;
        if (mon_rx_dat.size() != 1 || mon_rx_dat[0] !== ~txmem[3][0]) begin
            failures++;
            $display("[TB] FAIL bp rx: got %0d bytes, required one byte %h", mon_rx_dat.size(), ~txmem[3][0]);
        end
        checks++; if (mon_done.size() != 1 || mon_done[0] != 3) begin failures++; $display("[TB] FAIL bp done: got %0d pulses, required one on req3", mon_done.size()); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [5*NREQ+16:0] rv;
        logic [5*NREQ+16:0] rexp;
        rexp = {{NREQ{1'b1}}, {(4*NREQ + 17){1'b0}}};
        clear_logs();
        @(posedge clock);
        #1;
        load_txn(1, 4);
        req = 4'b0010;
        n = 0;
        while (start_cnt < 1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        req = '0;
        #1;
        rv = {cs_n, grant, tx_ready, rx_valid, done, eng_start, eng_txd, rx_data};
        checks++; if (rv !== rexp) begin failures++; $display("[TB] FAIL midreset immediate: got %h required %h", rv, rexp); end
        repeat (3) begin
            @(negedge clock);
            rv = {cs_n, grant, tx_ready, rx_valid, done, eng_start, eng_txd, rx_data};
            checks++; if (rv !== rexp) begin failures++; $display("[TB] FAIL midreset held: got %h required %h", rv, rexp); end
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (mon_done.size() != 0) begin failures++; $display("[TB] FAIL midreset done: got %0d pulses required 0", mon_done.size()); end
        clear_logs();
        @(posedge clock);
        #1;
        load_txn(3, 2);
        req = 4'b1000;
        wait_idle(400);
        checks++; if (mon_grant.size() != 1 || mon_grant[0] != 3) begin failures++; $display("[TB] FAIL midreset regrant: got %0d grants, required one on req3", mon_grant.size()); end
        checks++; if (mon_rx_dat.size() != 2) begin failures++; $display("[TB] FAIL midreset rx count: got %0d required 2", mon_rx_dat.size()); end
        for (int k = 0; k < 2 && k < mon_rx_dat.size(); k++) begin
            checks++;
            if (mon_rx_dat[k] !== ~txmem[3][k]) begin
                failures++;
                $display("[TB] FAIL midreset rx[%0d]: got %h required %h", k, mon_rx_dat[k], ~txmem[3][k]);
            end
        end
        checks++; if (mon_done.size() != 1 || mon_done[0] != 3) begin failures++; $display("[TB] FAIL midreset final done: got %0d pulses, required one on req3", mon_done.size()); end
    endtask

    task automatic test_random();
        int lens [NREQ];
        logic [NREQ-1:0] mask;
        logic [NREQ-1:0] pend_m;
        int last;
        int own;
        int total;
        int exp_own[$];
        logic [7:0] exp_dat[$];
        int exp_done[$];
        pulse_reset();
        last = NREQ - 1;
        for (int r = 0; r < 6; r++) begin
            clear_logs();
            exp_own.delete();
            exp_dat.delete();
            exp_done.delete();
            @(posedge clock);
            #1;
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            total = 0;
            for (int i = 0; i < NREQ; i++) begin
                lens[i] = mask[i] ? $urandom_range(0, 3) : 0;
                if (mask[i]) load_txn(i, lens[i]);
            end
            pend_m = mask;
            while (pend_m != '0) begin
                own = rr_pick(last, pend_m);
                exp_done.push_back(own);
                for (int k = 0; k < lens[own]; k++) begin
                    exp_own.push_back(own);
                    exp_dat.push_back(~txmem[own][k]);
                end
                total += lens[own];
                pend_m[own] = 1'b0;
                last = own;
            end
            req = mask;
            wait_idle(2000);
            checks++; if (mon_done.size() != exp_done.size()) begin failures++; $display("[TB] FAIL rand%0d done count: got %0d required %0d", r, mon_done.size(), exp_done.size()); end
            for (int k = 0; k < exp_done.size() && k < mon_done.size(); k++) begin
                checks++;
                if (mon_done[k] != exp_done[k]) begin failures++; $display("[TB] FAIL rand%0d done[%0d]: got %0d required %0d", r, k, mon_done[k], exp_done[k]); end
            end
            checks++; if (mon_rx_dat.size() != exp_dat.size()) begin failures++; $display("[TB] FAIL rand%0d rx count: got %0d required %0d", r, mon_rx_dat.size(), exp_dat.size()); end
            for (int k = 0; k < exp_dat.size() && k < mon_rx_dat.size(); k++) begin
                checks++;
                if (mon_rx_own[k] != exp_own[k] || mon_rx_dat[k] !== exp_dat[k]) begin
                    failures++;
                    $display("[TB] FAIL rand%0d rx[%0d]: got req%0d %h required req%0d %h", r, k, mon_rx_own[k], mon_rx_dat[k], exp_own[k], exp_dat[k]);
                end
            end
            checks++; if (start_cnt != total) begin failures++; $display("[TB] FAIL rand%0d starts: got %0d required %0d", r, start_cnt, total); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_len_zero();
        test_abort();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
